load_store_unit: RTL and testbench

Initiator side of the data-memory interface. Accepts one load or store per handshake from the execute stage, breaks it into the byte-lane write strobes and read strobe the data memory understands, and returns load data aligned and sign/zero-extended. Sits between the execute stage and `data_mem`. Owns all lane selection and extension.

---
 rtl/load_store_unit_pkg.sv | 58 +++++
 rtl/load_store_unit_if.sv | 27 ++
 rtl/load_store_unit_load_align.sv | 28 ++
 rtl/load_store_unit.sv | 140 ++++++++++++++
 tb/tb_load_store_unit.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// load_store_unit shared definitions
// funct3 codes, FSM states, lane counts and request checks
package load_store_unit_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int MAX_D_MEM = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] LANES_B = 3'd1;
  localparam logic [2:0] LANES_H = 3'd2;
  localparam logic [2:0] LANES_W = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RESP
  } lsu_state_e;

  function automatic logic [2:0] lane_count(
    input logic [2:0] f3
  );
    logic [2:0] n;
    case (f3)
      F3_H, F3_HU: n = LANES_H;
      F3_W:        n = LANES_W;
      default:     n = LANES_B;
    endcase
    return n;
  endfunction

  // Illegal encoding, unsigned store, or misaligned access
  function automatic logic req_bad(
    input logic       st,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic bad;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = a[0];
      F3_W:    bad = |a;
      F3_BU:   bad = st;
      F3_HU:   bad = st | a[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-stage request/response channel
// of the load/store unit
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;

  modport master (
    output req_valid, req_store,
    output req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_misaligned
  );

  modport slave (
    input  req_valid, req_store,
    input  req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_misaligned
  );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Load data lane select and sign/zero extension
// Purely combinational
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] r_data,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = r_data[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? r_data[31:16]
                       : r_data[15:0];
    case (funct3)
      F3_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ext_data = {24'd0, byte_sel};
      F3_H:    ext_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ext_data = {16'd0, half_sel};
      default: ext_data = r_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: splits stores into single-lane
// writes, issues reads and aligns load data
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int D_ADDR_W = $clog2(MAX_D_MEM)
) (
  input  logic                clk,
  input  logic                rst,
  load_store_unit_if.slave    bus,
  output logic                wren,
  output logic                is_load,
  output logic [3:0]          mask_buffer,
  output logic [D_ADDR_W-1:0] r_addr,
  output logic [D_ADDR_W-1:0] w_addr,
  output logic [31:0]         w_data,
  input  logic [31:0]         r_data
);

  lsu_state_e          state, state_n;
  logic                st_q;
  logic [2:0]          f3_q;
  logic [D_ADDR_W+1:0] addr_q;
  logic [31:0]         wdata_q;
  logic [1:0]          cnt_q;
  logic [31:0]         rdata_q;
  logic                mis_q;
  logic [31:0]         ext_data;
  logic                accept;
  logic                bad_in;
  logic                last_lane;
  logic [1:0]          lane;
  logic [D_ADDR_W-1:0] word;
  logic                resp_valid;
  logic                unused_addr;

  assign unused_addr = ^bus.req_addr[31:D_ADDR_W+2];

  assign accept = bus.req_valid && state == S_IDLE;
  assign bad_in = req_bad(bus.req_store, bus.req_funct3,
                          bus.req_addr[1:0]);
  assign lane = addr_q[1:0] + cnt_q;
  assign word = addr_q[D_ADDR_W+1:2];
  assign last_lane =
    {1'b0, cnt_q} == lane_count(f3_q) - 3'd1;

  assign bus.req_ready       = state == S_IDLE;
  assign bus.resp_valid      = resp_valid;
  assign bus.resp_rdata      = rdata_q;
  assign bus.resp_misaligned = mis_q;

  load_align u_align (
    .r_data   (r_data),
    .addr     (addr_q[1:0]),
    .funct3   (f3_q),
    .ext_data (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      st_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        st_q    <= bus.req_store;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr[D_ADDR_W+1:0];
        wdata_q <= bus.req_wdata;
        mis_q   <= bad_in;
        cnt_q   <= '0;
      end
      if (state == S_WRITE) cnt_q <= cnt_q + 2'd1;
      if (state == S_RD_WAIT) rdata_q <= ext_data;
      if (state == S_RESP) begin
        rdata_q <= '0;
        mis_q   <= 1'b0;
      end
    end
  end

  always_comb begin
    state_n     = state;
    wren        = DISABLE;
    is_load     = DISABLE;
    mask_buffer = '0;
    r_addr      = '0;
    w_addr      = '0;
    w_data      = '0;
    resp_valid  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (bad_in)             state_n = S_RESP;
          else if (bus.req_store) state_n = S_WRITE;
          else                    state_n = S_RD_ISSUE;
        end
      end
      S_WRITE: begin
        wren        = ENABLE;
        mask_buffer = 4'b0001 << lane;
        w_addr      = word;
        w_data      = wdata_q << {addr_q[1:0], 3'b000};
        if (last_lane) state_n = S_RESP;
      end
      S_RD_ISSUE: begin
        wren    = ENABLE;
        is_load = ENABLE;
        r_addr  = word;
        state_n = S_RD_WAIT;
      end
      S_RD_WAIT: state_n = S_RESP;
      S_RESP: begin
        resp_valid = 1'b1;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Reset kills the in-flight access in its own cycle
    if (rst) begin
      wren        = DISABLE;
      is_load     = DISABLE;
      mask_buffer = '0;
      w_data      = '0;
      r_addr      = '0;
      w_addr      = '0;
      resp_valid  = 1'b0;
    end
  end

  logic unused_st;
  assign unused_st = st_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a
// behavioural 32-word byte-lane data memory
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int AW = 5;

  typedef struct {
    logic [31:0] data;
    logic        mis;
    int          lat;
  } resp_t;

  typedef struct {
    logic [3:0]  mask;
    logic [4:0]  addr;
    logic [31:0] data;
    int          off;
  } wr_t;

  typedef struct {
    logic [4:0] addr;
    int         off;
  } rd_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wren, is_load;
  logic [3:0]    mask_buffer;
  logic [AW-1:0] r_addr, w_addr;
  logic [31:0]   w_data, r_data;

  logic [31:0] mem [32];
  logic        poke_en = 1'b0;
  logic [4:0]  poke_addr = '0;
  logic [31:0] poke_data = '0;

  int cyc = 0;
  int last_acc = 0;
  int n_chk = 0;
  int n_fail = 0;

  resp_t exp_q[$];
  wr_t   wr_q[$];
  rd_t   rd_q[$];
  resp_t pe;
  wr_t   we;
  rd_t   re;

  load_store_unit_if bus();

  load_store_unit #(.D_ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .wren        (wren),
    .is_load     (is_load),
    .mask_buffer (mask_buffer),
    .r_addr      (r_addr),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .r_data      (r_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    if (wren && is_load && mask_buffer == 4'b0000)
      r_data <= mem[r_addr];
    if (wren && !is_load)
      for (int i = 0; i < 4; i++)
        if (mask_buffer[i])
          mem[w_addr][8*i +: 8] <= w_data[8*i +: 8];
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  // Monitor: compares memory strobes and responses
  always @(negedge clk) begin
    if (wren && !is_load) begin
      if (wr_q.size() == 0) fail_now("unexpected_write");
      else begin
        we = wr_q.pop_front();
        chk("wr_mask", {28'd0, mask_buffer}, {28'd0, we.mask});
        chk("wr_addr", {27'd0, w_addr}, {27'd0, we.addr});
        chk("wr_data", w_data, we.data);
        chk("wr_cycle", cyc - last_acc, we.off);
      end
    end
    if (wren && is_load) begin
      if (rd_q.size() == 0) fail_now("unexpected_read");
      else begin
        re = rd_q.pop_front();
        chk("rd_mask", {28'd0, mask_buffer}, 32'd0);
        chk("rd_addr", {27'd0, r_addr}, {27'd0, re.addr});
        chk("rd_cycle", cyc - last_acc, re.off);
      end
    end
    if (is_load && !wren) fail_now("is_load_without_wren");
    if (bus.resp_valid) begin
      if (exp_q.size() == 0) fail_now("unexpected_resp");
      else begin
        pe = exp_q.pop_front();
        chk("resp_rdata", bus.resp_rdata, pe.data);
        chk("resp_mis", {31'd0, bus.resp_misaligned},
            {31'd0, pe.mis});
        chk("resp_cycle", cyc - last_acc, pe.lat);
        chk("ready_in_resp", {31'd0, bus.req_ready}, 32'd0);
      end
    end
  end

  task automatic poke(input logic [4:0] a,
                      input logic [31:0] d);
    @(negedge clk);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic ex_wr(input logic [3:0] m,
                       input logic [4:0] a,
                       input logic [31:0] d,
                       input int off);
    wr_q.push_back('{m, a, d, off});
  endtask

  task automatic ex_rd(input logic [4:0] a);
    rd_q.push_back('{a, 1});
  endtask

  task automatic send(input logic st,
                      input logic [2:0] f3,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic [31:0] exp_d,
                      input logic exp_m,
                      input int lat,
                      input bit has_resp);
    int t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) fail_now("ready_timeout");
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    last_acc = cyc;
    if (has_resp) exp_q.push_back('{exp_d, exp_m, lat});
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || !bus.req_ready) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) fail_now("drain_timeout");
  endtask

  task automatic ld(input logic [2:0] f3,
                    input logic [31:0] a,
                    input logic [31:0] exp_d);
    ex_rd(a[6:2]);
    send(1'b0, f3, a, 32'd0, exp_d, 1'b0, 3, 1'b1);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mis", {31'd0, bus.resp_misaligned}, 32'd0);
    chk("rst_mem_ctl", {26'd0, wren, is_load, mask_buffer},
        32'd0);
    chk("rst_w_data", w_data, 32'd0);

    poke(5'd1, 32'h5555_6666);
    poke(5'd2, 32'h0000_0000);
    poke(5'd3, 32'h0000_0000);
    poke(5'd4, 32'hDEAD_BEEF);
    poke(5'd7, 32'h0000_0000);

    ld(F3_W, 32'h10, 32'hDEAD_BEEF);
    drain();

    poke(5'd4, 32'h80FF_7F01);
    ld(F3_B,  32'h13, 32'hFFFF_FF80);
    ld(F3_BU, 32'h13, 32'h0000_0080);
    ld(F3_H,  32'h12, 32'hFFFF_80FF);
    ld(F3_HU, 32'h10, 32'h0000_7F01);
    ld(F3_B,  32'h11, 32'h0000_007F);
    drain();

    for (int i = 0; i < 4; i++)
      ex_wr(4'(1 << i), 5'd2, 32'h1122_3344, i + 1);
    send(1'b1, F3_W, 32'h08, 32'h1122_3344, 0, 1'b0, 5, 1'b1);
    ld(F3_W, 32'h08, 32'h1122_3344);
    drain();

    ex_wr(4'b0100, 5'd1, 32'hABCD_0000, 1);
    ex_wr(4'b1000, 5'd1, 32'hABCD_0000, 2);
    send(1'b1, F3_H, 32'h06, 32'h0000_ABCD, 0, 1'b0, 3, 1'b1);
    drain();
    chk("sh_mem1", mem[1], 32'hABCD_6666);

    ex_wr(4'b0010, 5'd3, 32'h3456_5A00, 1);
    send(1'b1, F3_B, 32'h0D, 32'h1234_565A, 0, 1'b0, 2, 1'b1);
    ld(F3_BU, 32'h0D, 32'h0000_005A);
    drain();
    chk("sb_mem3", mem[3], 32'h0000_5A00);

    send(1'b0, F3_W,  32'h05, 0, 0, 1'b1, 1, 1'b1);
    send(1'b1, F3_BU, 32'h00, 32'hFF, 0, 1'b1, 1, 1'b1);
    send(1'b0, F3_H,  32'h03, 0, 0, 1'b1, 1, 1'b1);
    send(1'b0, 3'b011, 32'h00, 0, 0, 1'b1, 1, 1'b1);
    send(1'b1, F3_HU, 32'h04, 32'h1, 0, 1'b1, 1, 1'b1);
    drain();

    ex_wr(4'b0001, 5'd7, 32'hCAFE_F00D, 1);
    send(1'b1, F3_W, 32'h1C, 32'hCAFE_F00D, 0, 1'b0, 5, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("mid_rst_resp", {31'd0, bus.resp_valid}, 32'd0);
    chk("mid_rst_wren", {31'd0, wren}, 32'd0);
    repeat (6) @(negedge clk);
    chk("mid_rst_mem7", mem[7], 32'h0000_000D);
    ld(F3_W, 32'h1C, 32'h0000_000D);
    drain();

    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("wr_q_empty", wr_q.size(), 32'd0);
    chk("rd_q_empty", rd_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
